// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with writeback bypass, hazard scoreboard and output buffer
//
// Purpose:
//   Sits between decode and execute, directly upstream of the register file
//   read ports. Each accepted instruction has its source operands read, with
//   same-cycle writeback data bypassed in. Its operands are then captured
//   into a single-entry output buffer. A busy-bit scoreboard tracks
//   destination registers that are still outstanding. Any instruction that
//   reads or rewrites such a register is stalled (RAW/WAW).
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   in_valid/in_ready    decoded instruction handshake
//   in_rs1/in_rs2/in_rd  source and destination register indices
//   in_rd_en             instruction writes in_rd
//   in_pc/in_ctrl        PC and opaque control bundle, passed through
//   rf_readA/rf_readB    register file read addresses (combinational)
//   rf_A/rf_B            register file read data
//   wb_en/wb_rd/wb_data  writeback bus (same bus that writes the register file)
//   flush                squashes the buffered instruction
//   out_valid/out_ready  execute handshake
//   out_*                buffered operands, rd, rd_en, PC and control
module operand_fetch #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_en,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_readA,
  output logic [4:0]        rf_readB,
  input  logic [XLEN-1:0]   rf_A,
  input  logic [XLEN-1:0]   rf_B,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rd,
  output logic              out_rd_en,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic [31:0]       busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_en_q, rd_en_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic              hazard;
  logic              accept;
  logic [XLEN-1:0]   rs1_sel, rs2_sel;

  // A register being written back this cycle is no longer outstanding.
  function automatic logic clr(input logic [4:0] r);
    return wb_en && (wb_rd == r);
  endfunction

  function automatic logic eff_busy(input logic [4:0] r);
    return busy_q[r] && !clr(r);
  endfunction

  // The register file only updates at the edge, so same-cycle writeback
  // data must be forwarded here. x0 always reads as zero.
  function automatic logic [XLEN-1:0] sel_operand(input logic [4:0]      r,
                                                  input logic [XLEN-1:0] rf_val);
    if (r == 5'd0) begin
      return '0;
    end else if (clr(r)) begin
      return wb_data;
    end else begin
      return rf_val;
    end
  endfunction

  assign rf_readA = in_rs1;
  assign rf_readB = in_rs2;

  assign hazard   = in_valid && (eff_busy(in_rs1) || eff_busy(in_rs2) ||
                                 (in_rd_en && eff_busy(in_rd)));
  assign in_ready = !hazard && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign rs1_sel  = sel_operand(in_rs1, rf_A);
  assign rs2_sel  = sel_operand(in_rs2, rf_B);

  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (flush) begin
      // The squashed instruction will never write back, so release its rd.
      if (out_valid_q && rd_en_q) begin
        busy_d[rd_q] = 1'b0;
      end
    end else if (accept && in_rd_en && (in_rd != 5'd0)) begin
      // Applied after the writeback clear so a same-register set wins.
      busy_d[in_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    rd_d        = rd_q;
    rd_en_d     = rd_en_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rs1_val_d   = rs1_sel;
      rs2_val_d   = rs2_sel;
      rd_d        = in_rd;
      rd_en_d     = in_rd_en;
      pc_d        = in_pc;
      ctrl_d      = in_ctrl;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      pc_q        <= '0;
      ctrl_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      rd_q        <= rd_d;
      rd_en_q     <= rd_en_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_rd      = rd_q;
  assign out_rd_en   = rd_en_q;
  assign out_pc      = pc_q;
  assign out_ctrl    = ctrl_q;

endmodule
